// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with per-channel debounced duty up/down buttons and period-boundary duty update.
// Define PWM_CENTER_ALIGNED_EN for an up/down triangle counter; the default build is edge-aligned.
`timescale 1ns/1ps
module pwm_multi_channel #(
  parameter int CHANNELS               = 4,
  parameter int WIDTH                  = 8,
  parameter int PERIOD                 = 200,
  parameter int STEP                   = 20,
  parameter int DUTY_INIT              = 100,
  parameter int LIMIT_COUNTER_DEBOUNCE = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] inc_duty,
  input  logic [CHANNELS-1:0] dec_duty,
  output logic [CHANNELS-1:0] PWM_OUT,
  output logic                period_tick
);
  localparam int NB   = 2 * CHANNELS;
  localparam int DB_W = (LIMIT_COUNTER_DEBOUNCE > 1) ? $clog2(LIMIT_COUNTER_DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(LIMIT_COUNTER_DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH:0]   PERIOD_X = (WIDTH+1)'(PERIOD);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_INIT);

  function automatic logic [WIDTH-1:0] duty_inc(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    s = {1'b0, d} + STEP_X;
    if (s > PERIOD_X) s = PERIOD_X;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] duty_dec(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    s = {1'b0, d};
    if (s < STEP_X) s = '0;
    else            s = s - STEP_X;
    return s[WIDTH-1:0];
  endfunction

  logic [NB-1:0]      btn;
  logic [NB-1:0]      sync1_q, sync2_q;
  logic [NB-1:0]      lvl_q, lvl_d, press_q, press_d;
  logic [DB_W-1:0]    dbc_q [NB];
  logic [DB_W-1:0]    dbc_d [NB];
  logic [WIDTH-1:0]   shadow_q [CHANNELS];
  logic [WIDTH-1:0]   shadow_d [CHANNELS];
  logic [WIDTH-1:0]   active_q [CHANNELS];
  logic [WIDTH-1:0]   active_d [CHANNELS];
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               wrap;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic               tick_q, tick_d;
`ifdef PWM_CENTER_ALIGNED_EN
  logic               dir_q, dir_d;
`endif

  // Bits [CHANNELS-1:0] are increase buttons, the upper half are decrease buttons.
  assign btn = {dec_duty, inc_duty};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    for (int b = 0; b < NB; b++) begin
      dbc_d[b] = '0;
      if (sync2_q[b] != lvl_q[b]) begin
        if (dbc_q[b] == DB_MAX) begin
          lvl_d[b]   = ~lvl_q[b];
          press_d[b] = ~lvl_q[b];
        end else begin
          dbc_d[b] = dbc_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q   <= '0;
      press_q <= '0;
      for (int b = 0; b < NB; b++) dbc_q[b] <= '0;
    end else begin
      lvl_q   <= lvl_d;
      press_q <= press_d;
      dbc_q   <= dbc_d;
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  // Triangle: up 0..PERIOD-1, hold the peak once, down to 0; wrap marks the up-ramp start.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!dir_q) begin
      if (cnt_q == CNT_MAX) dir_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else begin
      if (cnt_q == '0) begin
        dir_d = 1'b0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end
`else
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  // Presses land in the shadow; the active duty only follows it at a period boundary or while idle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (press_q[i] && !press_q[CHANNELS+i])      shadow_d[i] = duty_inc(shadow_q[i]);
      else if (press_q[CHANNELS+i] && !press_q[i]) shadow_d[i] = duty_dec(shadow_q[i]);
      active_d[i] = (!en || wrap) ? shadow_q[i] : active_q[i];
    end
  end

  always_comb begin
    pwm_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = en && (({1'b0, cnt_q} + {1'b0, active_q[i]}) >= PERIOD_X);
    tick_d = en && (cnt_q == '0) && !dir_q;
`else
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = en && (cnt_q < active_q[i]);
    tick_d = en && (cnt_q == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pwm_q  <= '0;
      tick_q <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q  <= 1'b0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= DUTY_RST;
        active_q[i] <= DUTY_RST;
      end
    end else begin
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= dir_d;
`endif
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign PWM_OUT     = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: vector table of button presses with measured duty, corner
// sequences for reset/enable, and randomized buttons checked cycle by cycle against a window model.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int P    = 10;
  localparam int STEP = 2;
  localparam int DI   = 4;
  localparam int LIM  = 10;
  localparam int NB   = 2 * CH;
  localparam int HL   = LIM + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CH-1:0] inc_duty;
  logic [CH-1:0] dec_duty;
  logic [CH-1:0] pwm;
  logic          tick;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .CHANNELS(CH), .WIDTH(W), .PERIOD(P), .STEP(STEP),
    .DUTY_INIT(DI), .LIMIT_COUNTER_DEBOUNCE(LIM)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .inc_duty(inc_duty), .dec_duty(dec_duty),
    .PWM_OUT(pwm), .period_tick(tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press is a button whose synchronised samples (raw delayed by two
  // edges) have disagreed with the debounced level for the last LIM edges.
  bit [HL-1:0]   hist [NB];
  bit            m_lvl [NB];
  bit            m_pend [NB];
  int            m_shadow [CH];
  int            m_active [CH];
  int            m_phase;
  bit [CH-1:0]   exp_pwm;
  bit            exp_tick;
  bit [NB-1:0]   m_raw;
  bit            m_flip;
  bit            mon_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        hist[b] = '0; m_lvl[b] = 1'b0; m_pend[b] = 1'b0;
      end
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = DI; m_active[i] = DI;
      end
      m_phase = 0; exp_pwm = '0; exp_tick = 1'b0;
    end else begin
      m_raw = {dec_duty, inc_duty};
      for (int i = 0; i < CH; i++) exp_pwm[i] = en && (m_phase < m_active[i]);
      exp_tick = en && (m_phase == 0);
      for (int i = 0; i < CH; i++)
        if (!en || m_phase == P - 1) m_active[i] = m_shadow[i];
      for (int i = 0; i < CH; i++) begin
        if (m_pend[i] && !m_pend[CH+i])
          m_shadow[i] = (m_shadow[i] + STEP > P) ? P : m_shadow[i] + STEP;
        else if (m_pend[CH+i] && !m_pend[i])
          m_shadow[i] = (m_shadow[i] < STEP) ? 0 : m_shadow[i] - STEP;
      end
      for (int b = 0; b < NB; b++) begin
        hist[b] = {hist[b][HL-2:0], m_raw[b]};
        m_flip = 1'b1;
        for (int k = 2; k < HL; k++) if (hist[b][k] == m_lvl[b]) m_flip = 1'b0;
        m_pend[b] = m_flip && !m_lvl[b];
        if (m_flip) m_lvl[b] = !m_lvl[b];
      end
      m_phase = en ? (m_phase + 1) % P : 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("model_pwm", int'(pwm), int'(exp_pwm));
      check("model_tick", int'(tick), int'(exp_tick));
    end
  end

  typedef struct {
    string         name;
    bit [CH-1:0]   inc;
    bit [CH-1:0]   dec;
    int            hold;
    int            d0;
    int            d1;
  } vec_t;

  vec_t tbl [13];

  task automatic press(input bit [CH-1:0] i_b, input bit [CH-1:0] d_b, input int hold);
    @(negedge clk);
    inc_duty = i_b; dec_duty = d_b;
    repeat (hold) @(negedge clk);
    inc_duty = '0; dec_duty = '0;
    repeat (LIM + 8) @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 3 * P && !found; c++) begin
      @(posedge clk); #1;
      if (tick) found = 1'b1;
    end
    if (!found) check({name, "_tick_timeout"}, 0, 1);
  endtask

  task automatic measure(input string name, output int h0, output int h1);
    wait_tick(name);
    h0 = int'(pwm[0]); h1 = int'(pwm[1]);
    for (int c = 1; c < P; c++) begin
      @(posedge clk); #1;
      h0 += int'(pwm[0]); h1 += int'(pwm[1]);
    end
  endtask

  int h0, h1;

  initial begin
    tbl[0]  = '{"basic",      2'b00, 2'b00, 0,  4,  4};
    tbl[1]  = '{"clean_inc",  2'b01, 2'b00, 20, 6,  4};
    tbl[2]  = '{"glitch",     2'b01, 2'b00, 5,  6,  4};
    tbl[3]  = '{"sat_inc8",   2'b01, 2'b00, 20, 8,  4};
    tbl[4]  = '{"sat_inc10",  2'b01, 2'b00, 20, 10, 4};
    tbl[5]  = '{"sat_hold10", 2'b01, 2'b00, 20, 10, 4};
    tbl[6]  = '{"dec8",       2'b00, 2'b01, 20, 8,  4};
    tbl[7]  = '{"dec6",       2'b00, 2'b01, 20, 6,  4};
    tbl[8]  = '{"dec4",       2'b00, 2'b01, 20, 4,  4};
    tbl[9]  = '{"dec2",       2'b00, 2'b01, 20, 2,  4};
    tbl[10] = '{"dec0",       2'b00, 2'b01, 20, 0,  4};
    tbl[11] = '{"dec_floor",  2'b00, 2'b01, 20, 0,  4};
    tbl[12] = '{"simult",     2'b11, 2'b10, 20, 2,  4};

    rst = 1'b1; en = 1'b1; inc_duty = '0; dec_duty = '0;
    #3;
    check("rst_pwm", int'(pwm), 0);
    check("rst_tick", int'(tick), 0);
    mon_en = 1'b1;
    #97;
    check("rst_pwm_late", int'(pwm), 0);
    rst = 1'b0;

    wait_tick("first");
    check("tick_rise_align", int'(pwm), 3);

    for (int v = 0; v < 13; v++) begin
      press(tbl[v].inc, tbl[v].dec, tbl[v].hold);
      measure(tbl[v].name, h0, h1);
      check({tbl[v].name, "_ch0"}, h0, tbl[v].d0);
      check({tbl[v].name, "_ch1"}, h1, tbl[v].d1);
    end

    // Asynchronous reset while both outputs are high mid-period.
    wait_tick("pre_rst");
    #2;
    check("pre_rst_high", int'(pwm), 3);
    rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_tick", int'(tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure("post_rst", h0, h1);
    check("post_rst_ch0", h0, DI);
    check("post_rst_ch1", h1, DI);

    // Enable low holds outputs off; re-enable ticks on the first enabled edge.
    @(negedge clk);
    en = 1'b0;
    repeat (15) @(negedge clk);
    check("en_off_pwm", int'(pwm), 0);
    check("en_off_tick", int'(tick), 0);
    en = 1'b1;
    @(posedge clk); #1;
    check("en_rise_tick", int'(tick), 1);
    @(posedge clk); #1;
    check("en_rise_tick_next", int'(tick), 0);

    // Randomized buttons and enable, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 11) == 0) inc_duty[i] = ~inc_duty[i];
        if ($urandom_range(0, 11) == 0) dec_duty[i] = ~dec_duty[i];
      end
      if ($urandom_range(0, 199) == 0) en = ~en;
    end
    @(negedge clk);
    inc_duty = '0; dec_duty = '0; en = 1'b1;
    repeat (40) @(negedge clk);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
